// File: rtl/wpn_attack_if.sv
// rtl/wpn_attack_if.sv - control and sprite/hit signals of the weapon attack sequencer
interface wpn_attack_if;
   logic       frame_tick;
   logic       mouse_left;
   logic       attack_en;
   logic       flip_h;
   logic       draw_weapon;
   logic [2:0] wpn_pose;
   logic       wpn_flip;
   logic       hit_active;
   logic       busy;
   logic [7:0] attack_cnt;

   modport slave (
      input  frame_tick, mouse_left, attack_en, flip_h,
      output draw_weapon, wpn_pose, wpn_flip, hit_active, busy, attack_cnt
   );

   modport master (
      output frame_tick, mouse_left, attack_en, flip_h,
      input  draw_weapon, wpn_pose, wpn_flip, hit_active, busy, attack_cnt
   );
endinterface

// File: rtl/wpn_attack_ctrl.sv
// rtl/wpn_attack_ctrl.sv - melee attack sequencer: WINDUP/SWING/RECOVER/COOLDOWN paced by frame ticks
module wpn_attack_ctrl #(
   parameter int WINDUP_FRAMES   = 3,
   parameter int SWING_FRAMES    = 8,
   parameter int RECOVER_FRAMES  = 4,
   parameter int COOLDOWN_FRAMES = 10,
   parameter int POSE_MAX        = 7
) (
   input logic         clk,
   input logic         rst_n,
   wpn_attack_if.slave bus
);
   localparam int CW = 8;

   typedef enum logic [2:0] {
      S_IDLE, S_WINDUP, S_SWING, S_RECOVER, S_COOLDOWN
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] lim;
   logic          pending;
   logic          sync1, sync2, sync3, press;
   logic          expire;
   logic          draw_r, flip_r, hit_r, busy_r;
   logic [2:0]    pose_r;
   logic [7:0]    acnt_r;

   // press is registered so the WINDUP entry lands exactly three clocks after capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
         sync3 <= 1'b0;
         press <= 1'b0;
      end else begin
         sync1 <= bus.mouse_left;
         sync2 <= sync1;
         sync3 <= sync2;
         press <= sync2 & ~sync3;
      end
   end

   always_comb begin
      lim = '0;
      case (state)
         S_WINDUP:   lim = CW'(WINDUP_FRAMES - 1);
         S_SWING:    lim = CW'(SWING_FRAMES - 1);
         S_RECOVER:  lim = CW'(RECOVER_FRAMES - 1);
         S_COOLDOWN: lim = CW'(COOLDOWN_FRAMES - 1);
         default:    lim = '0;
      endcase
   end

   assign expire = bus.frame_tick && (cnt == lim);

   // outputs are updated together with the state so hit_active never outlives SWING
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         cnt     <= '0;
         pending <= 1'b0;
         draw_r  <= 1'b0;
         pose_r  <= 3'd0;
         flip_r  <= 1'b0;
         hit_r   <= 1'b0;
         busy_r  <= 1'b0;
         acnt_r  <= 8'd0;
      end else if (!bus.attack_en) begin
         state   <= S_IDLE;
         cnt     <= '0;
         pending <= 1'b0;
         draw_r  <= 1'b0;
         pose_r  <= 3'd0;
         hit_r   <= 1'b0;
         busy_r  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (press) begin
                  state  <= S_WINDUP;
                  cnt    <= '0;
                  flip_r <= bus.flip_h;
                  draw_r <= 1'b1;
                  pose_r <= 3'd0;
                  busy_r <= 1'b1;
               end
            end
            S_WINDUP: begin
               if (expire) begin
                  state  <= S_SWING;
                  cnt    <= '0;
                  pose_r <= 3'd0;
                  hit_r  <= 1'b1;
               end else if (bus.frame_tick) begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_SWING: begin
               if (expire) begin
                  state  <= S_RECOVER;
                  cnt    <= '0;
                  hit_r  <= 1'b0;
                  acnt_r <= acnt_r + 8'd1;
               end else if (bus.frame_tick) begin
                  cnt <= cnt + CW'(1);
                  if (pose_r < 3'(POSE_MAX))
                     pose_r <= pose_r + 3'd1;
               end
            end
            S_RECOVER: begin
               if (press)
                  pending <= 1'b1;
               if (expire) begin
                  state  <= S_COOLDOWN;
                  cnt    <= '0;
                  draw_r <= 1'b0;
                  pose_r <= 3'd0;
               end else if (bus.frame_tick) begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_COOLDOWN: begin
               if (expire) begin
                  cnt     <= '0;
                  pending <= 1'b0;
                  if (pending || press) begin
                     state  <= S_WINDUP;
                     flip_r <= bus.flip_h;
                     draw_r <= 1'b1;
                     pose_r <= 3'd0;
                  end else begin
                     state  <= S_IDLE;
                     busy_r <= 1'b0;
                  end
               end else begin
                  if (press)
                     pending <= 1'b1;
                  if (bus.frame_tick)
                     cnt <= cnt + CW'(1);
               end
            end
            default: begin
               state   <= S_IDLE;
               cnt     <= '0;
               pending <= 1'b0;
               draw_r  <= 1'b0;
               pose_r  <= 3'd0;
               hit_r   <= 1'b0;
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.draw_weapon = draw_r;
   assign bus.wpn_pose    = pose_r;
   assign bus.wpn_flip    = flip_r;
   assign bus.hit_active  = hit_r;
   assign bus.busy        = busy_r;
   assign bus.attack_cnt  = acnt_r;
endmodule

// File: tb/tb_wpn_attack_ctrl.sv
// tb/tb_wpn_attack_ctrl.sv - directed vector bench for wpn_attack_ctrl
module tb_wpn_attack_ctrl;
   localparam int OP_PRESS = 0;
   localparam int OP_TICK  = 1;

   typedef struct {
      int          op;
      logic        en;
      logic        fh;
      logic [14:0] exp;
   } vec_t;

   logic clk;
   logic rst_n;
   int   total;
   int   bad;
   vec_t vq[$];

   wpn_attack_if bus ();

   wpn_attack_ctrl dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [14:0] outs();
      return {bus.draw_weapon, bus.wpn_pose, bus.wpn_flip, bus.hit_active, bus.busy, bus.attack_cnt};
   endfunction

   function automatic logic [14:0] pk(input logic d, input logic [2:0] p, input logic wf,
                                      input logic h, input logic b, input logic [7:0] c);
      return {d, p, wf, h, b, c};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic push(input int op, input logic en, input logic fh, input logic d,
                       input logic [2:0] p, input logic wf, input logic h, input logic b,
                       input logic [7:0] c);
      vec_t v;
      v.op  = op;
      v.en  = en;
      v.fh  = fh;
      v.exp = pk(d, p, wf, h, b, c);
      vq.push_back(v);
   endtask

   // remainder of an attack after the WINDUP entry, ending back in IDLE
   task automatic push_tail(input logic f, input logic [7:0] c, input bit toggle);
      for (int i = 1; i <= 2; i++) push(OP_TICK, 1, f, 1, 0, f, 0, 1, c);
      push(OP_TICK, 1, f, 1, 0, f, 1, 1, c);
      for (int i = 1; i <= 7; i++)
         push(OP_TICK, 1, toggle ? logic'(i[0]) : f, 1, 3'(i), f, 1, 1, c);
      push(OP_TICK, 1, f, 1, 7, f, 0, 1, c + 8'd1);
      for (int i = 1; i <= 3; i++) push(OP_TICK, 1, f, 1, 7, f, 0, 1, c + 8'd1);
      push(OP_TICK, 1, f, 0, 0, f, 0, 1, c + 8'd1);
      for (int i = 1; i <= 9; i++) push(OP_TICK, 1, f, 0, 0, f, 0, 1, c + 8'd1);
      push(OP_TICK, 1, f, 0, 0, f, 0, 0, c + 8'd1);
   endtask

   task automatic do_press();
      @(negedge clk) bus.mouse_left = 1'b1;
      @(negedge clk) bus.mouse_left = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic do_tick();
      @(negedge clk) bus.frame_tick = 1'b1;
      @(negedge clk) bus.frame_tick = 1'b0;
      @(negedge clk);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) do_tick();
   endtask

   task automatic abort_pulse();
      @(negedge clk) bus.attack_en = 1'b0;
      @(negedge clk) bus.attack_en = 1'b1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst_n = 1'b0;
      bus.frame_tick = 1'b0;
      bus.mouse_left = 1'b0;
      bus.attack_en  = 1'b1;
      bus.flip_h     = 1'b0;
      #1 check("reset_outputs", 32'(outs()), 32'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // reset asserted in the middle of SWING
      do_press();
      ticks(3);
      check("pre_reset_swing", 32'(outs()), 32'(pk(1, 0, 0, 1, 1, 0)));
      @(negedge clk) #2 rst_n = 1'b0;
      #1 check("async_reset", 32'(outs()), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk) check("post_reset_idle", 32'(outs()), 32'd0);

      // single attack with facing toggled during SWING, then buffered requests
      push(OP_PRESS, 1, 1, 1, 0, 1, 0, 1, 0);
      push_tail(1, 0, 1);
      push(OP_PRESS, 0, 0, 0, 0, 1, 0, 0, 1);
      push(OP_PRESS, 1, 0, 1, 0, 0, 0, 1, 1);
      for (int i = 1; i <= 2; i++) push(OP_TICK, 1, 0, 1, 0, 0, 0, 1, 1);
      push(OP_TICK, 1, 0, 1, 0, 0, 1, 1, 1);
      for (int i = 1; i <= 3; i++) push(OP_TICK, 1, 0, 1, 3'(i), 0, 1, 1, 1);
      push(OP_PRESS, 1, 0, 1, 3, 0, 1, 1, 1);
      for (int i = 4; i <= 7; i++) push(OP_TICK, 1, 0, 1, 3'(i), 0, 1, 1, 1);
      push(OP_TICK, 1, 0, 1, 7, 0, 0, 1, 2);
      push(OP_PRESS, 1, 0, 1, 7, 0, 0, 1, 2);
      for (int i = 1; i <= 3; i++) push(OP_TICK, 1, 0, 1, 7, 0, 0, 1, 2);
      push(OP_TICK, 1, 0, 0, 0, 0, 0, 1, 2);
      for (int i = 1; i <= 9; i++) begin
         push(OP_TICK, 1, 0, 0, 0, 0, 0, 1, 2);
         if (i == 2 || i == 4 || i == 6) push(OP_PRESS, 1, 0, 0, 0, 0, 0, 1, 2);
      end
      push(OP_TICK, 1, 1, 1, 0, 1, 0, 1, 2);
      push_tail(1, 2, 0);
      push(OP_TICK, 1, 0, 0, 0, 1, 0, 0, 3);

      foreach (vq[k]) begin
         bus.attack_en = vq[k].en;
         bus.flip_h    = vq[k].fh;
         if (vq[k].op == OP_PRESS) do_press();
         else do_tick();
         check($sformatf("vec%0d", k), 32'(outs()), 32'(vq[k].exp));
      end

      // abort at SWING tick 4
      bus.flip_h = 1'b0;
      do_press();
      ticks(7);
      check("abort_pre", 32'(outs()), 32'(pk(1, 4, 0, 1, 1, 3)));
      @(negedge clk) bus.attack_en = 1'b0;
      @(negedge clk) check("abort_idle", 32'(outs()), 32'(pk(0, 0, 0, 0, 0, 3)));
      bus.attack_en = 1'b1;
      do_tick();
      check("abort_stays_idle", 32'(outs()), 32'(pk(0, 0, 0, 0, 0, 3)));

      // pending request is dropped by an abort
      do_press();
      ticks(11);
      check("recover_reached", 32'(outs()), 32'(pk(1, 7, 0, 0, 1, 4)));
      do_press();
      abort_pulse();
      ticks(12);
      check("pending_cleared", 32'(outs()), 32'(pk(0, 0, 0, 0, 0, 4)));
      bus.flip_h = 1'b1;
      do_press();
      check("reenable_windup", 32'(outs()), 32'(pk(1, 0, 1, 0, 1, 4)));
      ticks(3);
      check("reenable_swing", 32'(outs()), 32'(pk(1, 0, 1, 1, 1, 4)));
      abort_pulse();

      // press-to-WINDUP latency counted from the capturing edge
      bus.flip_h = 1'b0;
      @(negedge clk) bus.mouse_left = 1'b1;
      @(posedge clk);
      @(negedge clk) bus.mouse_left = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 check("latency_n2", 32'(outs()), 32'(pk(0, 0, 1, 0, 0, 4)));
      @(posedge clk);
      #1 check("latency_n3", 32'(outs()), 32'(pk(1, 0, 0, 0, 1, 4)));
      abort_pulse();

      // one-period pulse at an arbitrary phase
      @(negedge clk);
      #3 bus.mouse_left = 1'b1;
      #10 bus.mouse_left = 1'b0;
      repeat (6) @(negedge clk);
      check("async_pulse", 32'(outs()), 32'(pk(1, 0, 0, 0, 1, 4)));
      abort_pulse();

      // held button yields a single attack
      bus.flip_h = 1'b1;
      @(negedge clk) bus.mouse_left = 1'b1;
      repeat (5) @(negedge clk);
      check("held_windup", 32'(outs()), 32'(pk(1, 0, 1, 0, 1, 4)));
      ticks(25);
      check("held_done", 32'(outs()), 32'(pk(0, 0, 1, 0, 0, 5)));
      ticks(4);
      check("held_no_retrigger", 32'(outs()), 32'(pk(0, 0, 1, 0, 0, 5)));
      @(negedge clk) bus.mouse_left = 1'b0;

      // attack_cnt wrap
      for (int s = 0; s < 250; s++) begin
         do_press();
         ticks(11);
         abort_pulse();
      end
      check("cnt_255", 32'(bus.attack_cnt), 32'd255);
      do_press();
      ticks(11);
      check("cnt_wrap", 32'(bus.attack_cnt), 32'd0);
      abort_pulse();
      check("cnt_wrap_idle", 32'(outs()), 32'(pk(0, 0, 1, 0, 0, 0)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
